// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter granting bursts of up to BURST beats from 3 requesters into an async FIFO write port.
// Define WR_ARB_OCC_EN to add a registered FIFO occupancy output computed from the gray write/read pointers.
module fifo_wr_arb #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic                  w_clk,
  input  logic                  w_rst_n,
  input  logic [2:0]            req_valid,
  input  logic [3*DATA_W-1:0]   req_data,
  output logic [2:0]            req_ready,
  input  logic                  w_full,
  output logic                  w_inc,
  output logic [DATA_W-1:0]     w_data,
  output logic [1:0]            grant_id,
  output logic                  busy
`ifdef WR_ARB_OCC_EN
  ,
  input  logic [3:0]            w_ptr,
  input  logic [3:0]            wq2_rptr,
  output logic [3:0]            occupancy
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d, last_q, last_d, c1, c2, pick;
  logic [3:0] cnt_q, cnt_d;
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  // Search order starts just after the last owner and wraps back to it.
  always_comb begin
    c1      = last_q == 2'd2 ? 2'd0 : last_q + 2'd1;
    c2      = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
    pick    = req_valid[c1] ? c1 : req_valid[c2] ? c2 : last_q;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (|req_valid) begin
        state_d = GRANT;
        owner_d = pick;
        cnt_d   = 4'd0;
      end
    end else begin
      cnt_d = cnt_q + {3'd0, w_inc};
      if (!req_valid[owner_q] || (w_inc && cnt_d == 4'(BURST))) begin
        state_d = IDLE;
        last_d  = owner_q;
      end
    end
  end
  always_comb begin
    busy      = state_q == GRANT;
    grant_id  = busy ? owner_q : 2'd3;
    w_inc     = busy && req_valid[owner_q] && !w_full;
    req_ready = (busy && !w_full) ? 3'(1) << owner_q : 3'd0;
    w_data    = req_data[owner_q*DATA_W +: DATA_W];
  end
`ifdef WR_ARB_OCC_EN
  function automatic logic [3:0] g2b(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction
  logic [3:0] occupancy_q, occupancy_d;
  always_comb occupancy_d = g2b(w_ptr) - g2b(wq2_rptr);
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) occupancy_q <= 4'd0;
    else          occupancy_q <= occupancy_d;
  end
  assign occupancy = occupancy_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed scenarios plus a random phase, each cycle checked against a behavioural arbiter model.
module tb_fifo_wr_arb;
  localparam int BURST = 4;
  logic        w_clk, w_rst_n, w_full, w_inc, busy;
  logic [2:0]  rv, req_ready;
  logic [23:0] rd;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;
`ifdef WR_ARB_OCC_EN
  logic [3:0]  w_ptr, wq2_rptr, occupancy;
`endif
  int checks = 0, errors = 0;
  int m_busy, m_own, m_beats, m_last, prev_busy;
  int base[3] = '{8'h10, 8'h20, 8'h30};
  int seq[3];
  logic [31:0] trace;
  logic [7:0]  dq[$];
  int          gq[$];

  fifo_wr_arb #(.DATA_W(8), .BURST(BURST)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .req_valid(rv), .req_data(rd), .req_ready(req_ready),
    .w_full(w_full), .w_inc(w_inc), .w_data(w_data), .grant_id(grant_id), .busy(busy)
`ifdef WR_ARB_OCC_EN
    , .w_ptr(w_ptr), .wq2_rptr(wq2_rptr), .occupancy(occupancy)
`endif
  );

  initial w_clk = 0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < 3; k++) rd[k*8 +: 8] = 8'(base[k] + seq[k]);
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_beats = 0; m_last = 2; prev_busy = 0;
    for (int k = 0; k < 3; k++) seq[k] = 0;
    drive_data();
  endtask

  task automatic do_reset();
    w_rst_n = 0; rv = 0; w_full = 0;
    model_reset();
    @(posedge w_clk); #1;
    w_rst_n = 1;
    trace = 0; dq.delete(); gq.delete();
  endtask

  // One clock: compare outputs with the model mid-cycle, then advance the model past the rising edge.
  task automatic step();
    int e_inc;
    bit found;
    @(negedge w_clk);
    e_inc = (m_busy && rv[m_own] && !w_full) ? 1 : 0;
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_busy ? m_own : 3);
    chk("w_inc", w_inc, e_inc);
    chk("req_ready", req_ready, (m_busy && !w_full) ? (1 << m_own) : 0);
    if (e_inc) chk("w_data", w_data, 8'(base[m_own] + seq[m_own]));
    trace = {trace[30:0], w_inc};
    if (w_inc) dq.push_back(w_data);
    if (busy && !prev_busy) gq.push_back(int'(grant_id));
    prev_busy = busy;
    @(posedge w_clk); #1;
    if (!m_busy) begin
      if (rv != 0) begin
        found = 0;
        for (int k = 1; k <= 3; k++)
          if (!found && rv[(m_last + k) % 3]) begin m_own = (m_last + k) % 3; found = 1; end
        m_busy = 1; m_beats = 0;
      end
    end else begin
      if (e_inc) begin m_beats++; seq[m_own]++; end
      if (!rv[m_own] || m_beats == BURST) begin m_busy = 0; m_last = m_own; end
    end
    drive_data();
  endtask

  initial begin
    w_rst_n = 0; rv = 3'b111; w_full = 0;
    model_reset();
`ifdef WR_ARB_OCC_EN
    w_ptr = 4'b0110; wq2_rptr = 4'b0001;
`endif
    #3;
    chk("rst_w_inc", w_inc, 0);
    chk("rst_grant_id", grant_id, 3);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
`ifdef WR_ARB_OCC_EN
    chk("rst_occupancy", occupancy, 0);
`endif
    @(posedge w_clk);
    do_reset();

    // Single requester: two back-to-back bursts with one idle cycle between.
    rv = 3'b001;
    for (int i = 0; i < 10; i++) step();
    chk("single_trace", trace[9:0], 10'b0111101111);
    chk("single_beats", dq.size(), 8);
    for (int i = 0; i < 8 && i < dq.size(); i++) chk("single_data", dq[i], 8'h10 + i);

    // All requesters valid: rotation 0,1,2,0.
    do_reset();
    rv = 3'b111;
    for (int i = 0; i < 20; i++) step();
    chk("rr_trace", trace[19:0], {4{5'b01111}});
    chk("rr_grants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("rr_order", gq[i], i % 3);

    // Full stall in the middle of a burst from requester 1.
    do_reset();
    rv = 3'b010;
    for (int i = 0; i < 3; i++) step();
    w_full = 1;
    for (int i = 0; i < 5; i++) step();
    w_full = 0;
    for (int i = 0; i < 3; i++) step();
    chk("stall_trace", trace[10:0], 11'b01100000110);
    chk("stall_beats", dq.size(), 4);

    // Owner 2 drops valid after one beat; pending requester 0 is next.
    do_reset();
    rv = 3'b100;
    step();
    rv = 3'b101;
    step();
    rv = 3'b001;
    for (int i = 0; i < 3; i++) step();
    chk("drop_trace", trace[4:0], 5'b01001);
    chk("drop_grants", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("drop_first", gq[0], 2);
      chk("drop_next", gq[1], 0);
    end

    // Asynchronous reset in the middle of a burst.
    do_reset();
    rv = 3'b111;
    step(); step(); step();
    chk("pre_async_busy", busy, 1);
    w_rst_n = 0;
    #2;
    chk("async_w_inc", w_inc, 0);
    chk("async_grant_id", grant_id, 3);
    chk("async_busy", busy, 0);
    chk("async_req_ready", req_ready, 0);
    model_reset();
    @(posedge w_clk); #1;
    w_rst_n = 1;
    gq.delete();
    step(); step();
    chk("post_rst_grants", gq.size(), 1);
    if (gq.size() == 1) chk("post_rst_owner", gq[0], 0);

`ifdef WR_ARB_OCC_EN
    w_ptr = 4'b0110; wq2_rptr = 4'b0001;
    @(posedge w_clk); #1;
    chk("occ_3", occupancy, 3);
    w_ptr = 4'b1100; wq2_rptr = 4'b0000;
    @(posedge w_clk); #1;
    chk("occ_8", occupancy, 8);
`endif

    // Random traffic and back-pressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rv = 3'($urandom_range(0, 7));
      w_full = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
